// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol transmitter.
// letter_to_code packs {len[2:0], code[4:0]}; code bit0 is sent first, 1 = dash.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_LGAP,
        ST_WGAP
    } state_t;

    localparam int DEF_UNIT_CYCLES      = 25_000_000;
    localparam int DEF_MAX_LEN          = 5;
    localparam int DEF_DASH_UNITS       = 3;
    localparam int DEF_GAP_UNITS        = 1;
    localparam int DEF_LETTER_GAP_UNITS = 3;
    localparam int DEF_WORD_GAP_UNITS   = 7;

    function automatic logic [7:0] letter_to_code(input logic [7:0] ascii);
        logic [7:0] ch;
        logic [7:0] res;
        ch  = (ascii >= 8'h61 && ascii <= 8'h7a) ? ascii - 8'h20 : ascii;
        res = 8'h00;
        case (ch)
            "A": res = {3'd2, 5'b00010};
            "B": res = {3'd4, 5'b00001};
            "C": res = {3'd4, 5'b00101};
            "D": res = {3'd3, 5'b00001};
            "E": res = {3'd1, 5'b00000};
            "F": res = {3'd4, 5'b00100};
            "G": res = {3'd3, 5'b00011};
            "H": res = {3'd4, 5'b00000};
            "I": res = {3'd2, 5'b00000};
            "J": res = {3'd4, 5'b01110};
            "K": res = {3'd3, 5'b00101};
            "L": res = {3'd4, 5'b00010};
            "M": res = {3'd2, 5'b00011};
            "N": res = {3'd2, 5'b00001};
            "O": res = {3'd3, 5'b00111};
            "P": res = {3'd4, 5'b00110};
            "Q": res = {3'd4, 5'b01011};
            "R": res = {3'd3, 5'b00010};
            "S": res = {3'd3, 5'b00000};
            "T": res = {3'd1, 5'b00001};
            "U": res = {3'd3, 5'b00100};
            "V": res = {3'd4, 5'b01000};
            "W": res = {3'd3, 5'b00110};
            "X": res = {3'd4, 5'b01001};
            "Y": res = {3'd4, 5'b01101};
            "Z": res = {3'd4, 5'b00011};
            "0": res = {3'd5, 5'b11111};
            "1": res = {3'd5, 5'b11110};
            "2": res = {3'd5, 5'b11100};
            "3": res = {3'd5, 5'b11000};
            "4": res = {3'd5, 5'b10000};
            "5": res = {3'd5, 5'b00000};
            "6": res = {3'd5, 5'b00001};
            "7": res = {3'd5, 5'b00011};
            "8": res = {3'd5, 5'b00111};
            "9": res = {3'd5, 5'b01111};
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit timer: counts 0..UNIT_CYCLES-1 while enabled, pulses unit_tick on the last count.
// Held at zero when disabled or cleared so every phase starts on a fresh unit boundary.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic unit_tick
);

    localparam int CW = $clog2(UNIT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          last;

    always_comb begin
        last    = (count_q == CW'(UNIT_CYCLES - 1));
        count_d = count_q + CW'(1);
        if (clr || !en || last) begin
            count_d = '0;
        end
    end

    assign unit_tick = en && last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/morse_sym_tx.sv
// Morse symbol transmitter: takes one dot/dash pattern per handshake and drives light_on
// with unit-exact mark, element gap, letter gap and word gap timing.
//
// state   | meaning
// IDLE    | ready for a symbol, light off, timer held
// MARK    | light on for one element (1 unit dot, DASH_UNITS dash)
// SPACE   | gap between elements of one symbol
// LGAP    | trailing gap after last element; done on its final cycle
// WGAP    | word gap for a zero-length symbol; done on its final cycle
module morse_sym_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = DEF_UNIT_CYCLES,
    parameter int MAX_LEN          = DEF_MAX_LEN,
    parameter int DASH_UNITS       = DEF_DASH_UNITS,
    parameter int GAP_UNITS        = DEF_GAP_UNITS,
    parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
    parameter int WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             sym_valid,
    input  logic [MAX_LEN-1:0]               sym_code,
    input  logic [$clog2(MAX_LEN+1)-1:0]     sym_len,
    output logic                             sym_ready,
    input  logic                             abort,
    output logic                             light_on,
    output logic                             busy,
    output logic                             done,
    output logic                             unit_tick
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int UW = $clog2(DASH_UNITS + GAP_UNITS + LETTER_GAP_UNITS + WORD_GAP_UNITS + 1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [LW-1:0]      elem_q, elem_d;
    logic [UW-1:0]      units_q, units_d;
    logic               light_q, light_d;
    logic               ready_q, ready_d;
    logic [LW-1:0]      len_clamped;
    logic               tick;
    logic               phase_end;
    logic               timer_clr;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (timer_clr),
        .en       (state_q != ST_IDLE),
        .unit_tick(tick)
    );

    // units_q holds the remaining ticks minus one, so the phase ends on the tick where it is zero
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        elem_d      = elem_q;
        units_d     = units_q;
        light_d     = light_q;
        len_clamped = (sym_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : sym_len;
        phase_end   = tick && (units_q == '0);
        timer_clr   = phase_end;

        if (abort) begin
            state_d   = ST_IDLE;
            code_d    = '0;
            elem_d    = '0;
            units_d   = '0;
            light_d   = 1'b0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sym_valid) begin
                        code_d = sym_code;
                        elem_d = len_clamped;
                        if (len_clamped == '0) begin
                            state_d = ST_WGAP;
                            units_d = UW'(WORD_GAP_UNITS - 1);
                            light_d = 1'b0;
                        end else begin
                            state_d = ST_MARK;
                            units_d = sym_code[0] ? UW'(DASH_UNITS - 1) : '0;
                            light_d = 1'b1;
                        end
                    end
                end
                ST_MARK: begin
                    if (phase_end) begin
                        code_d  = code_q >> 1;
                        elem_d  = elem_q - LW'(1);
                        light_d = 1'b0;
                        if (elem_q > LW'(1)) begin
                            state_d = ST_SPACE;
                            units_d = UW'(GAP_UNITS - 1);
                        end else begin
                            state_d = ST_LGAP;
                            units_d = UW'(LETTER_GAP_UNITS - 1);
                        end
                    end else if (tick) begin
                        units_d = units_q - UW'(1);
                    end
                end
                ST_SPACE: begin
                    if (phase_end) begin
                        state_d = ST_MARK;
                        units_d = code_q[0] ? UW'(DASH_UNITS - 1) : '0;
                        light_d = 1'b1;
                    end else if (tick) begin
                        units_d = units_q - UW'(1);
                    end
                end
                ST_LGAP, ST_WGAP: begin
                    if (phase_end) begin
                        state_d = ST_IDLE;
                        code_d  = '0;
                        elem_d  = '0;
                        units_d = '0;
                    end else if (tick) begin
                        units_d = units_q - UW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    light_d = 1'b0;
                end
            endcase
        end
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            elem_q  <= '0;
            units_q <= '0;
            light_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            elem_q  <= elem_d;
            units_q <= units_d;
            light_q <= light_d;
            ready_q <= ready_d;
        end
    end

    assign sym_ready = ready_q;
    assign busy      = ~ready_q;
    assign light_on  = light_q;
    assign unit_tick = tick;
    // an abort landing on the last gap cycle suppresses the completion pulse
    assign done      = phase_end && !abort && (state_q == ST_LGAP || state_q == ST_WGAP);

endmodule

// File: tb/tb_morse_sym_tx.sv
// Directed bench for morse_sym_tx with UNIT_CYCLES=4: symbol table plus back-to-back,
// abort and mid-symbol reset sequences.
module tb_morse_sym_tx;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sym_valid;
    logic [4:0] sym_code;
    logic [2:0] sym_len;
    logic       sym_ready;
    logic       abort;
    logic       light_on;
    logic       busy;
    logic       done;
    logic       unit_tick;

    int total = 0;
    int bad   = 0;

    morse_sym_tx #(
        .UNIT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sym_valid(sym_valid),
        .sym_code (sym_code),
        .sym_len  (sym_len),
        .sym_ready(sym_ready),
        .abort    (abort),
        .light_on (light_on),
        .busy     (busy),
        .done     (done),
        .unit_tick(unit_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [4:0] code;
        logic [2:0] len;
        int         exp_done;
        int         exp_on;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sends one symbol and follows it to done, checking the light waveform cycle by cycle.
    task automatic run_sym(input string nm, input logic [4:0] code, input logic [2:0] len,
                           input int exp_done, input int exp_on);
        bit exp_q[$];
        int l, k, done_at, on_cnt, tick_cnt, light_err, ready_err;
        l = (len > 3'd5) ? 5 : int'(len);
        for (int e = 0; e < l; e++) begin
            for (int c = 0; c < (code[e] ? 12 : 4); c++) exp_q.push_back(1'b1);
            for (int c = 0; c < ((e == l - 1) ? 12 : 4); c++) exp_q.push_back(1'b0);
        end
        if (l == 0) for (int c = 0; c < 28; c++) exp_q.push_back(1'b0);

        @(negedge clk);
        sym_valid = 1'b1;
        sym_code  = code;
        sym_len   = len;
        @(negedge clk);
        sym_valid = 1'b0;
        done_at = 0; on_cnt = 0; tick_cnt = 0; light_err = 0; ready_err = 0;
        k = 1;
        while (k <= 300) begin
            if (light_on !== ((k <= exp_q.size()) ? exp_q[k-1] : 1'b0)) light_err++;
            if (sym_ready !== 1'b0 || busy !== 1'b1) ready_err++;
            on_cnt   += int'(light_on);
            tick_cnt += int'(unit_tick);
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        check({nm, " done_cycle"}, done_at, exp_done);
        check({nm, " on_cycles"}, on_cnt, exp_on);
        check({nm, " unit_ticks"}, tick_cnt, exp_done / 4);
        check({nm, " light_trace_errs"}, light_err, 0);
        check({nm, " busy_errs"}, ready_err, 0);
        @(negedge clk);
        check({nm, " ready_after"}, int'(sym_ready), 1);
        check({nm, " light_after"}, int'(light_on), 0);
    endtask

    initial begin
        int k, done_cnt, tick_cnt;

        vecs[0] = '{"A",     5'b00010, 3'd2, 32, 16};
        vecs[1] = '{"E",     5'b00000, 3'd1, 16, 4};
        vecs[2] = '{"T",     5'b00001, 3'd1, 24, 12};
        vecs[3] = '{"O",     5'b00111, 3'd3, 56, 36};
        vecs[4] = '{"word",  5'b00000, 3'd0, 28, 0};
        vecs[5] = '{"clamp", 5'b11111, 3'd7, 88, 60};
        vecs[6] = '{"five",  5'b00000, 3'd5, 48, 20};
        vecs[7] = '{"Q",     5'b01011, 3'd4, 64, 40};

        reset_n   = 1'b0;
        sym_valid = 1'b0;
        sym_code  = '0;
        sym_len   = '0;
        abort     = 1'b0;
        #12;
        check("rst light", int'(light_on), 0);
        check("rst ready", int'(sym_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst tick", int'(unit_tick), 0);
        reset_n = 1'b1;

        check("pkg A", int'(letter_to_code(8'h41)), int'({3'd2, 5'b00010}));
        check("pkg o", int'(letter_to_code(8'h6f)), int'({3'd3, 5'b00111}));
        check("pkg space", int'(letter_to_code(8'h20)), 0);

        foreach (vecs[i]) run_sym(vecs[i].nm, vecs[i].code, vecs[i].len, vecs[i].exp_done, vecs[i].exp_on);

        // E then T with valid held throughout
        @(negedge clk);
        sym_valid = 1'b1;
        sym_code  = 5'b00000;
        sym_len   = 3'd1;
        @(negedge clk);
        k = 1;
        done_cnt = 0;
        while (k <= 40 && done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check("b2b E done_cycle", k, 16);
        sym_code = 5'b00001;
        @(negedge clk);
        check("b2b idle ready", int'(sym_ready), 1);
        check("b2b idle light", int'(light_on), 0);
        @(negedge clk);
        check("b2b T light", int'(light_on), 1);
        check("b2b T busy", int'(busy), 1);
        sym_valid = 1'b0;
        k = 1;
        tick_cnt = 0;
        while (k <= 40 && done !== 1'b1) begin
            tick_cnt += int'(light_on);
            @(negedge clk);
            k++;
        end
        check("b2b T done_cycle", k, 24);
        check("b2b T on_cycles", tick_cnt, 12);
        @(negedge clk);
        check("b2b ready_after", int'(sym_ready), 1);

        // abort 6 cycles into O
        @(negedge clk);
        sym_valid = 1'b1;
        sym_code  = 5'b00111;
        sym_len   = 3'd3;
        @(negedge clk);
        sym_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort pre light", int'(light_on), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort light", int'(light_on), 0);
        check("abort ready", int'(sym_ready), 1);
        done_cnt = 0;
        tick_cnt = 0;
        repeat (60) begin
            done_cnt += int'(done);
            tick_cnt += int'(unit_tick);
            @(negedge clk);
        end
        check("abort no_done", done_cnt, 0);
        check("abort no_tick", tick_cnt, 0);

        // abort wins over a simultaneous offer in IDLE
        sym_valid = 1'b1;
        abort     = 1'b1;
        sym_code  = 5'b00000;
        sym_len   = 3'd1;
        @(negedge clk);
        sym_valid = 1'b0;
        abort     = 1'b0;
        check("abort_idle ready", int'(sym_ready), 1);
        check("abort_idle light", int'(light_on), 0);

        // asynchronous reset in the middle of a dash
        sym_valid = 1'b1;
        sym_code  = 5'b00001;
        sym_len   = 3'd1;
        @(negedge clk);
        sym_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid pre light", int'(light_on), 1);
        reset_n = 1'b0;
        #1;
        check("rstmid light", int'(light_on), 0);
        check("rstmid ready", int'(sym_ready), 1);
        check("rstmid done", int'(done), 0);
        #2;
        reset_n = 1'b1;
        run_sym("A_after_rst", 5'b00010, 3'd2, 32, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
